// File: rtl/fact_core_slave.sv
// fact_core_slave: memory-mapped factorial engine.
// The host loads an operand N and writes opstart. The engine then multiplies
// a 128-bit accumulator by a down-counter, one step per clock, until the
// counter reaches 1. Completion raises done, and optionally the level
// interrupt. Reads are registered with one cycle of latency.
module fact_core_slave #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              interrupt
);

  localparam int RES_W  = 2 * DATA_W;
  localparam int PROD_W = 3 * DATA_W;

  localparam logic [2:0] REG_START   = 3'd0;
  localparam logic [2:0] REG_CLEAR   = 3'd1;
  localparam logic [2:0] REG_INTR_EN = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;
  localparam logic [2:0] REG_OPERAND = 3'd4;
  localparam logic [2:0] REG_RES_H   = 3'd5;
  localparam logic [2:0] REG_RES_L   = 3'd6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  operand;
  logic [DATA_W-1:0]  count;
  logic [RES_W-1:0]   result;
  logic               intr_en;
  logic               done;
  logic               overflow;

  logic [2:0]         idx;
  logic               wr_en, rd_en;
  logic               start_req, clear_req;
  logic               last_step;
  logic               busy;
  logic [PROD_W-1:0]  product;
  logic [DATA_W-1:0]  rdata;

  // Address bits outside the register index are decoded upstream.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_addr[ADDR_W-1:6], s_addr[2:0]};

  assign idx       = s_addr[5:3];
  assign wr_en     = s_sel & s_wr;
  assign rd_en     = s_sel & ~s_wr;
  assign start_req = wr_en && (idx == REG_START) && s_din[0];
  assign clear_req = wr_en && (idx == REG_CLEAR) && s_din[0];
  assign last_step = (count <= DATA_W'(1));
  assign busy      = (state == BUSY);
  assign interrupt = intr_en & done;

  // Full-width product. The upper third flags loss of significant bits.
  assign product = {{DATA_W{1'b0}}, result} * {{RES_W{1'b0}}, count};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic. Clear wins over everything else.
  always_comb begin
    state_nxt = state;
    if (clear_req) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start_req) state_nxt = BUSY;
        BUSY:       if (last_step) state_nxt = DONE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  // Interrupt enable is host-owned and survives opclear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           intr_en <= 1'b0;
    else if (wr_en && idx == REG_INTR_EN)   intr_en <= s_din[0];
  end

  // Engine datapath: operand capture, multiply/count-down, and flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      operand  <= '0;
      count    <= '0;
      result   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (clear_req) begin
      operand  <= '0;
      count    <= '0;
      result   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // The running computation works from count, so it ignores operand writes.
      if (wr_en && idx == REG_OPERAND) operand <= s_din;
      case (state)
        IDLE, DONE: begin
          if (start_req) begin
            result   <= RES_W'(1);
            count    <= operand;
            done     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        BUSY: begin
          if (last_step) begin
            done <= 1'b1;
          end else begin
            result <= product[RES_W-1:0];
            count  <= count - DATA_W'(1);
            if (|product[PROD_W-1:RES_W]) overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read mux. Write-only and reserved slots return zero.
  always_comb begin
    rdata = '0;
    case (idx)
      REG_INTR_EN: rdata = {{(DATA_W-1){1'b0}}, intr_en};
      REG_STATUS:  rdata = {{(DATA_W-3){1'b0}}, overflow, busy, done};
      REG_OPERAND: rdata = operand;
      REG_RES_H:   rdata = result[RES_W-1:DATA_W];
      REG_RES_L:   rdata = result[DATA_W-1:0];
      default:     rdata = '0;
    endcase
  end

  // Registered read return. It samples the pre-edge register values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   s_dout <= '0;
    else if (rd_en) s_dout <= rdata;
  end

endmodule

// File: tb/tb_fact_core_slave.sv
// Testbench for fact_core_slave. It uses directed and random factorial runs.
// Results are checked against an exact wide-integer factorial, reduced mod 2^128.
module tb_fact_core_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_sel;
  logic        s_wr;
  logic [15:0] s_addr;
  logic [63:0] s_din;
  logic [63:0] s_dout;
  logic        interrupt;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] A_START   = 16'h7000;
  localparam logic [15:0] A_CLEAR   = 16'h7008;
  localparam logic [15:0] A_INTR    = 16'h7010;
  localparam logic [15:0] A_STATUS  = 16'h7018;
  localparam logic [15:0] A_OPERAND = 16'h7020;
  localparam logic [15:0] A_RES_H   = 16'h7028;
  localparam logic [15:0] A_RES_L   = 16'h7030;
  localparam logic [15:0] A_RSVD    = 16'h7038;

  fact_core_slave #(.DATA_W(64), .ADDR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr),
    .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact N!, wide enough that no truncation occurs for the operands used here.
  function automatic logic [1023:0] fact(input int n);
    logic [1023:0] f;
    f = 1024'(1);
    for (int i = 2; i <= n; i++) f = f * 1024'(i);
    return f;
  endfunction

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
    @(posedge clk); #1;
    s_sel = 1'b0; s_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [63:0] d);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
    @(posedge clk); #1;
    s_sel = 1'b0;
    d = s_dout;
  endtask

  // Poll status until done is set. Returns the number of reads needed.
  task automatic poll_done(output int polls, output logic [63:0] st);
    polls = 0;
    do begin
      rd(A_STATUS, st);
      polls++;
    end while (st[0] !== 1'b1 && polls < 300);
  endtask

  task automatic run(input int n, input bit ie);
    logic [1023:0] f;
    logic [63:0]   st, v;
    int            polls, lat;
    bit            ov;
    f   = fact(n);
    ov  = |f[1023:128];
    lat = (n < 1) ? 1 : n;
    wr(A_OPERAND, 64'(n));
    wr(A_INTR, {63'd0, ie});
    wr(A_START, 64'd1);
    rd(A_STATUS, st);
    check($sformatf("busy_after_start_n%0d", n), st, 64'h2);
    poll_done(polls, st);
    // A read reports the state as it was before its own edge.
    check($sformatf("latency_n%0d", n), 64'(polls + 1), 64'(lat + 1));
    check($sformatf("status_done_n%0d", n), st, ov ? 64'h5 : 64'h1);
    check($sformatf("interrupt_n%0d", n), {63'd0, interrupt}, {63'd0, ie});
    rd(A_RES_H, v);
    check($sformatf("result_h_n%0d", n), v, f[127:64]);
    rd(A_RES_L, v);
    check($sformatf("result_l_n%0d", n), v, f[63:0]);
  endtask

  initial begin
    logic [63:0] v, st;
    int polls;
    reset_n = 1'b0; s_sel = 1'b0; s_wr = 1'b0; s_addr = '0; s_din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", s_dout, 64'h0);
    check("reset_intr", {63'd0, interrupt}, 64'h0);
    @(negedge clk); reset_n = 1'b1;
    rd(A_STATUS, v);  check("reset_status", v, 64'h0);
    rd(A_RES_L, v);   check("reset_res_l", v, 64'h0);

    // N=5 with the interrupt enabled.
    run(5, 1'b1);
    rd(A_RES_L, v);   check("res_l_5_const", v, 64'h78);
    wr(A_RES_L, 64'hDEAD_BEEF);
    rd(A_RES_L, v);   check("ro_write_ignored", v, 64'h78);
    wr(A_RSVD, 64'hFF);
    rd(A_RSVD, v);    check("reserved_reads_0", v, 64'h0);
    rd(A_START, v);   check("wo_reads_0", v, 64'h0);
    wr(A_INTR, 64'h0);
    check("intr_off_clears", {63'd0, interrupt}, 64'h0);

    // Degenerate operands, with the interrupt disabled.
    run(0, 1'b0);
    run(1, 1'b0);

    // The 128-bit boundary.
    run(34, 1'b1);
    rd(A_RES_H, v);   check("res_h_34_const", v, 64'hDE1BC4D19EFCAC82);
    rd(A_RES_L, v);   check("res_l_34_const", v, 64'h445DA75B00000000);
    run(35, 1'b1);

    // Random operands.
    for (int i = 0; i < 6; i++) run(int'($urandom_range(0, 45)), 1'($urandom_range(0, 1)));

    // Start again and write the operand while busy. Both must leave the run untouched.
    wr(A_INTR, 64'h1);
    wr(A_OPERAND, 64'd20);
    wr(A_START, 64'd1);
    wr(A_START, 64'd1);
    wr(A_OPERAND, 64'd3);
    poll_done(polls, st);
    check("midbusy_latency", 64'(polls), 64'd19);
    check("midbusy_status", st, 64'h1);
    rd(A_RES_L, v);   check("midbusy_res_l", v, 64'h21C3677C82B40000);
    rd(A_RES_H, v);   check("midbusy_res_h", v, 64'h0);
    rd(A_OPERAND, v); check("midbusy_operand", v, 64'd3);
    check("midbusy_intr", {63'd0, interrupt}, 64'h1);
    wr(A_CLEAR, 64'h1);
    check("clear_intr", {63'd0, interrupt}, 64'h0);
    rd(A_STATUS, v);  check("clear_status", v, 64'h0);
    rd(A_RES_L, v);   check("clear_res_l", v, 64'h0);
    rd(A_RES_H, v);   check("clear_res_h", v, 64'h0);
    rd(A_OPERAND, v); check("clear_operand", v, 64'h0);
    rd(A_INTR, v);    check("clear_keeps_ie", v, 64'h1);

    // Asynchronous reset while busy.
    wr(A_OPERAND, 64'd30);
    wr(A_START, 64'd1);
    rd(A_OPERAND, v); check("pre_reset_dout", v, 64'd30);
    @(negedge clk); reset_n = 1'b0;
    #1;
    check("async_reset_dout", s_dout, 64'h0);
    check("async_reset_intr", {63'd0, interrupt}, 64'h0);
    #3 reset_n = 1'b1;
    rd(A_STATUS, v);  check("post_reset_status", v, 64'h0);
    rd(A_OPERAND, v); check("post_reset_operand", v, 64'h0);
    rd(A_INTR, v);    check("post_reset_ie", v, 64'h0);
    rd(A_RES_L, v);   check("post_reset_res_l", v, 64'h0);
    run(4, 1'b1);
    rd(A_RES_L, v);   check("res_l_4_const", v, 64'd24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
